// File: rtl/mul_mdc_cfg_master_pkg.sv
// Shared types and register map for the mul_mdc configuration master.
package mul_mdc_package;

  typedef enum logic [3:0] {
    CM_IDLE,
    CM_ACQ_REQ,
    CM_ACQ_WAIT,
    CM_ACQ_GAP,
    CM_WR_LOAD,
    CM_WR_REQ,
    CM_TRIG_REQ,
    CM_STAT_REQ,
    CM_STAT_WAIT,
    CM_STAT_GAP
  } cfg_master_state_t;

  localparam logic [31:0] MUL_MDC_CFG_TRIGGER = 32'h0000_0000;
  localparam logic [31:0] MUL_MDC_CFG_ACQUIRE = 32'h0000_0004;
  localparam logic [31:0] MUL_MDC_CFG_STATUS  = 32'h0000_000C;
  localparam logic [31:0] MUL_MDC_ACQ_FAIL    = 32'hFFFF_FFFF;

  // Job register byte address; idx is zero-extended, sum wraps modulo 2^32.
  function automatic logic [31:0] job_reg_addr(input logic [31:0] base,
                                               input logic [31:0] off,
                                               input logic [7:0]  idx);
    return base + off + {22'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/mul_mdc_cfg_poll_timer.sv
// Down-counter pacing the gap between acquire/status polls.
module mul_mdc_cfg_poll_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                      r_cnt <= '0;
    else if (load_i)                r_cnt <= load_val_i;
    else if (en_i && r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign expired_o = (r_cnt == '0);

endmodule

// File: rtl/mul_mdc_cfg_master.sv
// Peripheral-bus initiator: acquire a context, write job registers, trigger, poll status.
module mul_mdc_cfg_master
  import mul_mdc_package::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] JOB_REG_OFFSET = 32'h40,
  parameter int unsigned POLL_GAP       = 8,
  parameter int unsigned ACQ_RETRY_MAX  = 255,
  parameter int unsigned ID             = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [7:0]    cmd_idx_i,
  input  logic [31:0]   cmd_data_i,
  input  logic          cmd_last_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [7:0]    job_id_o,
  output logic          periph_req_o,
  input  logic          periph_gnt_i,
  output logic [31:0]   periph_add_o,
  output logic          periph_wen_o,
  output logic [3:0]    periph_be_o,
  output logic [31:0]   periph_data_o,
  output logic [ID-1:0] periph_id_o,
  input  logic          periph_r_valid_i,
  input  logic [31:0]   periph_r_data_i,
  input  logic [ID-1:0] periph_r_id_i
);

  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam int unsigned RW = $clog2(ACQ_RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(ACQ_RETRY_MAX);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(POLL_GAP - 1);

  cfg_master_state_t r_state, w_next;

  logic          r_req, r_wen, r_done, r_err, r_last;
  logic [31:0]   r_add, r_wdata, r_cmd_data;
  logic [3:0]    r_be;
  logic [7:0]    r_job_id, r_idx;
  logic [RW-1:0] r_retry;

  logic          w_granted, w_acq_fail, w_retry_out, w_gap_load, w_expired, w_in_gap;
  logic [RW-1:0] w_retry_nxt;
  logic          w_unused;

  assign w_unused    = ^periph_r_id_i;
  assign w_granted   = r_req && periph_gnt_i;
  assign w_acq_fail  = (periph_r_data_i == MUL_MDC_ACQ_FAIL);
  assign w_retry_nxt = r_retry + RW'(1);
  assign w_retry_out = (w_retry_nxt == RETRY_LIM);
  assign w_in_gap    = (r_state == CM_ACQ_GAP) || (r_state == CM_STAT_GAP);

  mul_mdc_cfg_poll_timer #(.W(GW)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_gap_load),
    .load_val_i (GAP_LOAD),
    .en_i       (w_in_gap),
    .expired_o  (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= CM_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_gap_load = 1'b0;
    case (r_state)
      CM_IDLE:      if (start_i) w_next = CM_ACQ_REQ;
      CM_ACQ_REQ:   if (w_granted) w_next = CM_ACQ_WAIT;
      CM_ACQ_WAIT:
        if (periph_r_valid_i) begin
          if (!w_acq_fail)      w_next = CM_WR_LOAD;
          else if (w_retry_out) w_next = CM_IDLE;
          else begin
            w_next     = CM_ACQ_GAP;
            w_gap_load = 1'b1;
          end
        end
      CM_ACQ_GAP:   if (w_expired) w_next = CM_ACQ_REQ;
      CM_WR_LOAD:   if (cmd_valid_i) w_next = CM_WR_REQ;
      CM_WR_REQ:    if (w_granted) w_next = r_last ? CM_TRIG_REQ : CM_WR_LOAD;
      CM_TRIG_REQ:  if (w_granted) w_next = CM_STAT_REQ;
      CM_STAT_REQ:  if (w_granted) w_next = CM_STAT_WAIT;
      CM_STAT_WAIT:
        if (periph_r_valid_i) begin
          if (periph_r_data_i == 32'h0) w_next = CM_IDLE;
          else begin
            w_next     = CM_STAT_GAP;
            w_gap_load = 1'b1;
          end
        end
      CM_STAT_GAP:  if (w_expired) w_next = CM_STAT_REQ;
      default:      w_next = CM_IDLE;
    endcase
  end

  // Bus outputs load on the first cycle of a *_REQ state and hold until granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req <= 1'b0;  r_add <= '0;  r_wen <= 1'b1;  r_be <= '0;  r_wdata <= '0;
      r_done <= 1'b0; r_err <= 1'b0; r_job_id <= '0; r_retry <= '0;
      r_idx <= '0;    r_cmd_data <= '0; r_last <= 1'b0;
    end else begin
      r_done <= (r_state == CM_STAT_WAIT) && periph_r_valid_i && (periph_r_data_i == 32'h0);
      r_err  <= (r_state == CM_ACQ_WAIT) && periph_r_valid_i && w_acq_fail && w_retry_out;
      if (r_state == CM_ACQ_WAIT && periph_r_valid_i) begin
        if (!w_acq_fail) begin
          r_job_id <= periph_r_data_i[7:0];
          r_retry  <= '0;
        end else begin
          r_retry  <= w_retry_out ? '0 : w_retry_nxt;
        end
      end
      if (r_state == CM_WR_LOAD && cmd_valid_i) begin
        r_idx      <= cmd_idx_i;
        r_cmd_data <= cmd_data_i;
        r_last     <= cmd_last_i;
      end
      if (r_req) begin
        if (periph_gnt_i) r_req <= 1'b0;
      end else begin
        case (r_state)
          CM_ACQ_REQ: begin
            r_req <= 1'b1; r_wen <= 1'b1; r_be <= 4'hF; r_wdata <= '0;
            r_add <= BASE_ADDR + MUL_MDC_CFG_ACQUIRE;
          end
          CM_WR_REQ: begin
            r_req <= 1'b1; r_wen <= 1'b0; r_be <= 4'hF; r_wdata <= r_cmd_data;
            r_add <= job_reg_addr(BASE_ADDR, JOB_REG_OFFSET, r_idx);
          end
          CM_TRIG_REQ: begin
            r_req <= 1'b1; r_wen <= 1'b0; r_be <= 4'hF; r_wdata <= '0;
            r_add <= BASE_ADDR + MUL_MDC_CFG_TRIGGER;
          end
          CM_STAT_REQ: begin
            r_req <= 1'b1; r_wen <= 1'b1; r_be <= 4'hF; r_wdata <= '0;
            r_add <= BASE_ADDR + MUL_MDC_CFG_STATUS;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready_o   = (r_state == CM_WR_LOAD);
  assign busy_o        = (r_state != CM_IDLE);
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign job_id_o      = r_job_id;
  assign periph_req_o  = r_req;
  assign periph_add_o  = r_add;
  assign periph_wen_o  = r_wen;
  assign periph_be_o   = r_be;
  assign periph_data_o = r_wdata;
  assign periph_id_o   = '0;

endmodule

// File: tb/tb_mul_mdc_cfg_master.sv
// Directed bench: scripted slave, expected-transaction model, per-cycle bus checker.
module tb_mul_mdc_cfg_master;

  localparam int POLL_GAP = 3;
  localparam int RETRY    = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic cmd_valid = 1'b0, cmd_last = 1'b0, cmd_ready;
  logic [7:0] cmd_idx = '0, job_id;
  logic [31:0] cmd_data = '0;
  logic busy, done, err;
  logic req, gnt = 1'b0, wen, rvalid, slv_rv = 1'b0, stray_rv = 1'b0;
  logic [31:0] add, wdata, rdata = '0;
  logic [3:0] be;
  logic [9:0] pid;

  assign rvalid = slv_rv | stray_rv;
  always #5 clk = ~clk;

  mul_mdc_cfg_master #(
    .BASE_ADDR(32'h0), .JOB_REG_OFFSET(32'h40), .POLL_GAP(POLL_GAP),
    .ACQ_RETRY_MAX(RETRY), .ID(10)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_idx_i(cmd_idx),
    .cmd_data_i(cmd_data), .cmd_last_i(cmd_last),
    .busy_o(busy), .done_o(done), .err_o(err), .job_id_o(job_id),
    .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add), .periph_wen_o(wen),
    .periph_be_o(be), .periph_data_o(wdata), .periph_id_o(pid),
    .periph_r_valid_i(rvalid), .periph_r_data_i(rdata), .periph_r_id_i(10'd0)
  );

  typedef struct packed { logic [31:0] addr; logic wen; logic [31:0] data; } txn_t;
  typedef struct packed { logic [7:0] idx; logic [31:0] data; logic last; } cmd_t;

  txn_t exp_q[$], act_q[$];
  cmd_t cq[$];
  logic [31:0] acq_resp[$], stat_resp[$];
  int gnt_delay = 0;
  int n_cmp = 0, n_fail = 0, done_cnt = 0, err_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endfunction

  function automatic logic [31:0] resp(txn_t t);
    if (t.wen && t.addr == 32'h4) begin
      if (acq_resp.size() > 0) return acq_resp.pop_front();
      return 32'hFFFF_FFFF;
    end
    if (t.wen && t.addr == 32'hC) begin
      if (stat_resp.size() > 0) return stat_resp.pop_front();
      return 32'h0;
    end
    return 32'h0;
  endfunction

  // Slave plus compare process; everything sampled at negedge, mid-cycle.
  int cyc = 0, wcnt = 0, last_gcyc = 0, k = 0;
  logic p_req = 1'b0, p_gnt = 1'b0, p_done = 1'b0, have_last = 1'b0;
  txn_t p_txn, last_g;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      gnt = 1'b0; slv_rv = 1'b0; rdata = '0; wcnt = 0;
      p_req = 1'b0; p_gnt = 1'b0; p_done = 1'b0; have_last = 1'b0;
    end else begin
      if (p_req && p_gnt) begin
        act_q.push_back(p_txn);
        last_g = p_txn; last_gcyc = cyc - 1; have_last = 1'b1;
        slv_rv = 1'b1; rdata = resp(p_txn);
      end else begin
        slv_rv = 1'b0; rdata = '0;
      end
      if (!busy) have_last = 1'b0;
      if (done) begin
        done_cnt++;
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("done_width", {31'd0, p_done}, 32'd0);
      end
      if (err) begin
        err_cnt++;
        check("busy_at_err", {31'd0, busy}, 32'd0);
      end
      if (req) begin
        k = act_q.size();
        if (k < exp_q.size()) begin
          check("bus_add", add, exp_q[k].addr);
          check("bus_wen", {31'd0, wen}, {31'd0, exp_q[k].wen});
          if (!wen) check("bus_wdata", wdata, exp_q[k].data);
        end else begin
          n_cmp++; n_fail++;
          $display("FAIL extra_txn: got request to %h, expected none", add);
        end
        check("bus_be", {28'd0, be}, 32'hF);
        check("bus_id", {22'd0, pid}, 32'd0);
        if (p_req && !p_gnt) begin
          check("hold_add", add, p_txn.addr);
          check("hold_wdata", wdata, p_txn.data);
          check("hold_wen", {31'd0, wen}, {31'd0, p_txn.wen});
        end
        if (!p_req && have_last && last_g.wen && wen && last_g.addr == add)
          check("poll_gap", cyc - last_gcyc, POLL_GAP + 3);
        gnt = (wcnt >= gnt_delay);
        wcnt++;
      end else begin
        gnt = 1'b0; wcnt = 0;
      end
      p_req = req; p_gnt = gnt; p_txn = '{addr: add, wen: wen, data: wdata};
      p_done = done;
    end
  end

  // Command feeder: handshake decided from values held stable across the next posedge.
  initial begin : feeder
    logic hs;
    hs = 1'b0;
    forever begin
      @(negedge clk);
      if (hs && cq.size() > 0) void'(cq.pop_front());
      if (cq.size() > 0 && !rst) begin
        cmd_valid = 1'b1; cmd_idx = cq[0].idx; cmd_data = cq[0].data; cmd_last = cq[0].last;
      end else begin
        cmd_valid = 1'b0;
      end
      hs = cmd_valid && cmd_ready && !rst;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic ex(logic [31:0] a, logic w, logic [31:0] d);
    exp_q.push_back('{addr: a, wen: w, data: d});
  endtask

  task automatic start_job();
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    check(name, {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic end_check(string name, int d, int e, logic [7:0] jid);
    $display("-- %s", name);
    check("txn_count", act_q.size(), exp_q.size());
    check("done_count", done_cnt, d);
    check("err_count", err_cnt, e);
    check("job_id", {24'd0, job_id}, {24'd0, jid});
  endtask

  task automatic check_reset_vals(string tag);
    $display("-- reset values %s", tag);
    check("rst_req", {31'd0, req}, 0);     check("rst_add", add, 0);
    check("rst_wen", {31'd0, wen}, 1);     check("rst_be", {28'd0, be}, 0);
    check("rst_data", wdata, 0);           check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);   check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);     check("rst_job_id", {24'd0, job_id}, 0);
  endtask

  int b;
  logic found;
  initial begin
    repeat (3) tick();
    check_reset_vals("power-on");
    rst = 1'b0; tick();

    // Basic job: three writes, status busy twice then idle.
    acq_resp = '{32'h7}; stat_resp = '{32'h1, 32'h1, 32'h0};
    ex(32'h4, 1, 0); ex(32'h40, 0, 32'hA); ex(32'h44, 0, 32'hB); ex(32'h48, 0, 32'hC);
    ex(32'h0, 0, 0); ex(32'hC, 1, 0); ex(32'hC, 1, 0); ex(32'hC, 1, 0);
    cq.push_back('{8'd0, 32'hA, 1'b0}); cq.push_back('{8'd1, 32'hB, 1'b0});
    cq.push_back('{8'd2, 32'hC, 1'b1});
    start_job(); wait_idle("t1_idle");
    end_check("t1", 1, 0, 8'h07);
    check("t1_lit_wr2_addr", act_q[3].addr, 32'h48);
    check("t1_lit_wr2_data", act_q[3].data, 32'hC);
    check("t1_lit_trig_addr", act_q[4].addr, 32'h0);

    // Two failed acquires, top register index exercises the address arithmetic.
    b = act_q.size();
    acq_resp = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5}; stat_resp = '{32'h0};
    ex(32'h4, 1, 0); ex(32'h4, 1, 0); ex(32'h4, 1, 0);
    ex(32'h43C, 0, 32'h1234); ex(32'h0, 0, 0); ex(32'hC, 1, 0);
    cq.push_back('{8'hFF, 32'h1234, 1'b1});
    start_job(); wait_idle("t2_idle");
    end_check("t2", 2, 0, 8'h05);
    check("t2_lit_wr_addr", act_q[b+3].addr, 32'h43C);

    // Acquire never succeeds: RETRY reads then err, no writes.
    b = act_q.size();
    acq_resp.delete();
    ex(32'h4, 1, 0); ex(32'h4, 1, 0); ex(32'h4, 1, 0);
    start_job(); wait_idle("t3_idle");
    end_check("t3", 2, 1, 8'h05);
    check("t3_lit_reads", act_q.size() - b, 3);

    // Every grant delayed by four cycles.
    gnt_delay = 4;
    acq_resp = '{32'h9}; stat_resp = '{32'h2, 32'h0};
    ex(32'h4, 1, 0); ex(32'h4C, 0, 32'hDEAD); ex(32'h50, 0, 32'hBEEF);
    ex(32'h0, 0, 0); ex(32'hC, 1, 0); ex(32'hC, 1, 0);
    cq.push_back('{8'd3, 32'hDEAD, 1'b0}); cq.push_back('{8'd4, 32'hBEEF, 1'b1});
    start_job(); wait_idle("t4_idle");
    end_check("t4", 3, 1, 8'h09);

    // Reset while a job-register write is pending.
    acq_resp = '{32'h1}; stat_resp = '{32'h0};
    ex(32'h4, 1, 0); ex(32'h54, 0, 32'h55);
    cq.push_back('{8'd5, 32'h55, 1'b1});
    start_job();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (req && !wen) found = 1'b1;
    end
    check("t5_wr_req_seen", {31'd0, found}, 32'd1);
    rst = 1'b1; tick();
    check_reset_vals("mid-job");
    tick();
    cq.delete(); acq_resp.delete(); stat_resp.delete();
    while (exp_q.size() > act_q.size()) void'(exp_q.pop_back());
    rst = 1'b0; gnt_delay = 0; tick();
    acq_resp = '{32'h2}; stat_resp = '{32'h0};
    ex(32'h4, 1, 0); ex(32'h44, 0, 32'h11); ex(32'h0, 0, 0); ex(32'hC, 1, 0);
    cq.push_back('{8'd1, 32'h11, 1'b1});
    start_job(); wait_idle("t5_idle");
    end_check("t5", 4, 1, 8'h02);

    // start_i and a stray r_valid while waiting for a command.
    b = act_q.size();
    acq_resp = '{32'h3}; stat_resp = '{32'h0};
    ex(32'h4, 1, 0); ex(32'h48, 0, 32'h22); ex(32'h0, 0, 0); ex(32'hC, 1, 0);
    start_job();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (cmd_ready) found = 1'b1;
    end
    check("t6_wr_load_seen", {31'd0, found}, 32'd1);
    start = 1'b1; stray_rv = 1'b1; tick(); start = 1'b0; stray_rv = 1'b0;
    tick(); tick();
    check("t6_still_ready", {31'd0, cmd_ready}, 32'd1);
    check("t6_still_busy", {31'd0, busy}, 32'd1);
    check("t6_no_done", done_cnt, 4);
    check("t6_no_new_txn", act_q.size() - b, 1);
    cq.push_back('{8'd2, 32'h22, 1'b1});
    wait_idle("t6_idle");
    end_check("t6", 5, 1, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
